// File: rtl/hello_world_sequencer_if.sv
// Signal bundle between the hello_world sequencer and the test harness driving it.
// The slave side is the sequencer. The master side is whatever supplies start/abort and the gate output.
interface hello_world_sequencer_if;
    logic       start;
    logic       abort;
    logic       F;
    logic       A;
    logic       B;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_mask;
    logic [1:0] vec_idx;

    modport master (
        output start, abort, F,
        input  A, B, busy, done, pass, err_mask, vec_idx
    );

    modport slave (
        input  start, abort, F,
        output A, B, busy, done, pass, err_mask, vec_idx
    );
endinterface

// File: rtl/hello_world_sequencer.sv
// Exhaustive exerciser for a 2-input gate: walks {B,A} through 00,01,10,11.
// Each vector is held HOLD_CYCLES clocks, and F is checked against EXPECT_TT on the last hold cycle.
module hello_world_sequencer #(
    parameter int         HOLD_CYCLES = 10,
    parameter logic [3:0] EXPECT_TT   = 4'b1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    hello_world_sequencer_if.slave  bus
);
    localparam int            CW   = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt,   w_cnt_nxt;
    logic [1:0]    r_vec,   w_vec_nxt;
    logic [3:0]    r_err,   w_err_nxt;
    logic          r_pass,  w_pass_nxt;
    logic          r_a,     w_a_nxt;
    logic          r_b,     w_b_nxt;
    logic          w_miss;

    // A four-state compare lets an X or Z on F in simulation count as a mismatch.
    assign w_miss = (bus.F !== EXPECT_TT[r_vec]);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_vec_nxt   = r_vec;
        w_err_nxt   = r_err;
        w_pass_nxt  = r_pass;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_APPLY;
                    w_cnt_nxt   = '0;
                    w_vec_nxt   = 2'd0;
                    w_err_nxt   = 4'd0;
                    w_pass_nxt  = 1'b0;
                end
            end
            S_APPLY: begin
                // Abort beats a sample on the same edge, so that vector's bit is left untouched.
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_vec_nxt   = 2'd0;
                    w_pass_nxt  = 1'b0;
                end else if (r_cnt == LAST) begin
                    w_err_nxt[r_vec] = w_miss;
                    w_cnt_nxt        = '0;
                    if (r_vec == 2'd3) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_vec_nxt = r_vec + 2'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_DONE: begin
                w_pass_nxt  = ~|r_err;
                w_state_nxt = S_IDLE;
                w_vec_nxt   = 2'd0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_vec_nxt   = 2'd0;
            end
        endcase
        w_a_nxt = (w_state_nxt == S_APPLY) & w_vec_nxt[0];
        w_b_nxt = (w_state_nxt == S_APPLY) & w_vec_nxt[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_vec   <= 2'd0;
            r_err   <= 4'd0;
            r_pass  <= 1'b0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_vec   <= w_vec_nxt;
            r_err   <= w_err_nxt;
            r_pass  <= w_pass_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
        end
    end

    assign bus.A        = r_a;
    assign bus.B        = r_b;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = (r_state == S_DONE);
    assign bus.pass     = r_pass;
    assign bus.err_mask = r_err;
    assign bus.vec_idx  = r_vec;
endmodule

// File: tb/tb_hello_world_sequencer.sv
// Bench for hello_world_sequencer: two instances (HOLD_CYCLES=10 and 1) receive the same stimulus.
// A timeline model checks every cycle, and literal checks pin that model at key points.
module tb_hello_world_sequencer;
    localparam int         HC[2] = '{10, 1};
    localparam logic [3:0] TT    = 4'b1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    int   fmode = 0;              // 0: AND gate, 1: F stuck 0, 2: F stuck 1
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    function automatic logic gate(int m, logic a, logic b);
        case (m)
            0:       return a & b;
            1:       return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    hello_world_sequencer_if if10 ();
    hello_world_sequencer_if if1 ();

    assign if10.start = start;
    assign if10.abort = abort;
    assign if10.F     = gate(fmode, if10.A, if10.B);
    assign if1.start  = start;
    assign if1.abort  = abort;
    assign if1.F      = gate(fmode, if1.A, if1.B);

    hello_world_sequencer #(.HOLD_CYCLES(10), .EXPECT_TT(TT)) u_dut10 (
        .clk(clk), .rst_n(rst_n), .bus(if10.slave));
    hello_world_sequencer #(.HOLD_CYCLES(1), .EXPECT_TT(TT)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));

    logic       o_a[2], o_b[2], o_busy[2], o_done[2], o_pass[2];
    logic [3:0] o_err[2];
    logic [1:0] o_vec[2];
    assign o_a[0] = if10.A;            assign o_a[1] = if1.A;
    assign o_b[0] = if10.B;            assign o_b[1] = if1.B;
    assign o_busy[0] = if10.busy;      assign o_busy[1] = if1.busy;
    assign o_done[0] = if10.done;      assign o_done[1] = if1.done;
    assign o_pass[0] = if10.pass;      assign o_pass[1] = if1.pass;
    assign o_err[0] = if10.err_mask;   assign o_err[1] = if1.err_mask;
    assign o_vec[0] = if10.vec_idx;    assign o_vec[1] = if1.vec_idx;

    // Model: a run is "start edge + elapsed edges". Vector k occupies elapsed edges [k*H, (k+1)*H).
    // The vector is judged at elapsed edge (k+1)*H. DONE is elapsed 4H, and elapsed 4H+1 returns to idle.
    bit         m_act[2]  = '{0, 0};
    int         m_e[2]    = '{0, 0};
    logic [3:0] m_err[2]  = '{4'd0, 4'd0};
    bit         m_pass[2] = '{0, 0};

    function automatic logic vec_miss(int m, int k);
        logic [3:0] tt;
        tt = TT;
        return gate(m, (k % 2) != 0, (k / 2) != 0) != tt[k];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_act[d]  <= 1'b0;
                m_e[d]    <= 0;
                m_err[d]  <= 4'd0;
                m_pass[d] <= 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (!m_act[d]) begin
                    if (start) begin
                        m_act[d]  <= 1'b1;
                        m_e[d]    <= 0;
                        m_err[d]  <= 4'd0;
                        m_pass[d] <= 1'b0;
                    end
                end else if (m_e[d] + 1 <= 4 * HC[d]) begin
                    m_e[d] <= m_e[d] + 1;
                    if (abort)
                        m_act[d] <= 1'b0;
                    else if ((m_e[d] + 1) % HC[d] == 0)
                        m_err[d][(m_e[d] + 1) / HC[d] - 1] <= vec_miss(fmode, (m_e[d] + 1) / HC[d] - 1);
                end else begin
                    m_pass[d] <= ~|m_err[d];
                    m_act[d]  <= 1'b0;
                end
            end
        end
    end

    task automatic chk(string nm, int d, logic [3:0] act, logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (H=%0d) at %0t: got %0h expected %0h", nm, HC[d], $time, act, exp);
        end
    endtask

    task automatic cmp_dut(int d);
        int e, h, v;
        bit ap, dn;
        e  = m_e[d];
        h  = HC[d];
        v  = e / h;
        ap = m_act[d] && (e < 4 * h);
        dn = m_act[d] && (e == 4 * h);
        chk("A",        d, 4'(o_a[d]),    ap ? 4'(v % 2) : 4'd0);
        chk("B",        d, 4'(o_b[d]),    ap ? 4'(v / 2) : 4'd0);
        chk("busy",     d, 4'(o_busy[d]), 4'(m_act[d]));
        chk("done",     d, 4'(o_done[d]), 4'(dn));
        chk("pass",     d, 4'(o_pass[d]), 4'(m_pass[d]));
        chk("err_mask", d, o_err[d],      m_err[d]);
        if (ap) chk("vec_idx", d, 4'(o_vec[d]), 4'(v));
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) cmp_dut(d);
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        // Reset state before any clock edge
        #1;
        chk("rst A",    0, 4'(if10.A),    4'd0);
        chk("rst B",    0, 4'(if10.B),    4'd0);
        chk("rst busy", 0, 4'(if10.busy), 4'd0);
        chk("rst done", 0, 4'(if10.done), 4'd0);
        chk("rst pass", 0, 4'(if10.pass), 4'd0);
        chk("rst err",  0, if10.err_mask, 4'd0);
        #12 rst_n = 1'b1;
        tick(1);

        // Correct AND gate: done appears after edge 4H
        fmode = 0;
        run_start();
        tick(3);
        chk("H1 vec3 A", 1, 4'(if1.A), 4'd1);
        chk("H1 vec3 B", 1, 4'(if1.B), 4'd1);
        tick(1);
        chk("H1 done@4", 1, 4'(if1.done), 4'd1);
        tick(11);
        chk("vec1 A", 0, 4'(if10.A), 4'd1);
        chk("vec1 B", 0, 4'(if10.B), 4'd0);
        tick(25);
        chk("done@40", 0, 4'(if10.done), 4'd1);
        chk("pass in DONE", 0, 4'(if10.pass), 4'd0);
        tick(1);
        chk("done clears", 0, 4'(if10.done), 4'd0);
        chk("AND pass", 0, 4'(if10.pass), 4'd1);
        chk("AND err", 0, if10.err_mask, 4'd0);
        chk("H1 AND pass", 1, 4'(if1.pass), 4'd1);
        tick(2);

        // Stuck-at faults on F
        fmode = 1;
        run_start();
        tick(41);
        chk("F0 err",  0, if10.err_mask, 4'b1000);
        chk("F0 pass", 0, 4'(if10.pass), 4'd0);
        fmode = 2;
        run_start();
        tick(41);
        chk("F1 err",  0, if10.err_mask, 4'b0111);
        chk("F1 pass", 0, 4'(if10.pass), 4'd0);
        tick(2);

        // Start re-pulsed while busy, including during DONE
        fmode = 0;
        run_start();
        tick(14);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("restart ignored vec", 0, 4'(if10.vec_idx), 4'd1);
        tick(24);
        start = 1'b1;
        tick(1);
        chk("done@40 again", 0, 4'(if10.done), 4'd1);
        tick(1);
        start = 1'b0;
        chk("DONE start ignored", 0, 4'(if10.busy), 4'd0);
        tick(1);
        chk("still idle", 0, 4'(if10.busy), 4'd0);
        chk("repulse pass", 0, 4'(if10.pass), 4'd1);
        tick(8);

        // Start and abort together in IDLE starts the run; abort in the third vector keeps the collected bits
        fmode = 2;
        start = 1'b1;
        abort = 1'b1;
        tick(1);
        start = 1'b0;
        abort = 1'b0;
        chk("start beats abort", 0, 4'(if10.busy), 4'd1);
        tick(24);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("abort busy", 0, 4'(if10.busy), 4'd0);
        chk("abort A",    0, 4'(if10.A),    4'd0);
        chk("abort B",    0, 4'(if10.B),    4'd0);
        chk("abort err",  0, if10.err_mask, 4'b0011);
        chk("abort pass", 0, 4'(if10.pass), 4'd0);
        tick(20);
        fmode = 0;
        run_start();
        tick(41);
        chk("post-abort pass", 0, 4'(if10.pass), 4'd1);

        // Abort on a sample edge wins over the sample
        fmode = 2;
        run_start();
        tick(19);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("abort@sample err", 0, if10.err_mask, 4'b0001);
        tick(5);

        // Asynchronous reset mid-run
        fmode = 0;
        run_start();
        tick(11);
        #2 rst_n = 1'b0;
        #1;
        chk("async busy", 0, 4'(if10.busy), 4'd0);
        chk("async A",    0, 4'(if10.A),    4'd0);
        chk("async vec",  0, 4'(if10.vec_idx), 4'd0);
        chk("async done", 0, 4'(if10.done), 4'd0);
        #4 rst_n = 1'b1;
        tick(1);
        run_start();
        tick(41);
        chk("post-reset pass", 0, 4'(if10.pass), 4'd1);
        chk("post-reset H1 pass", 1, 4'(if1.pass), 4'd1);
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
